// File: rtl/regs_wr_arb.sv
// rtl/regs_wr_arb.sv - single-port write arbiter for the general-purpose register file
//
// Merges three writers onto the one register-file write port.
// Priority per cycle: ex writeback > buffered divider result > jtag.
// Divider results pass through a one-entry buffer, which is exported as
// pend_valid_o/pend_addr_o so that id can stall readers of that register.
// Writes to x0 complete their handshake but never raise rf_we_o.
//
// Ports:
//   clk_i, rst_ni                        clock, asynchronous active-low reset
//   ex_we_i/ex_waddr_i/ex_wdata_i        ex writeback (never stalled)
//   div_valid_i/div_ready_o/div_waddr_i/div_wdata_i   divider result handshake
//   jtag_valid_i/jtag_ready_o/jtag_addr_i/jtag_data_i debug write handshake
//   rf_we_o/rf_waddr_o/rf_wdata_o        register-file write port (combinational)
//   pend_valid_o/pend_addr_o             buffered divider result
//   ex_stall_o                           ex must hold its next writeback
//
// Optional feature macro: REGS_ARB_STARVE_EN
//   When defined, a waiting jtag request is forced through after STARVE_MAX
//   cycles of waiting. When undefined, ex_stall_o is tied 0 and jtag may starve.
module regs_wr_arb #(
  parameter int AW         = 5,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          ex_we_i,
  input  logic [AW-1:0] ex_waddr_i,
  input  logic [DW-1:0] ex_wdata_i,
  input  logic          div_valid_i,
  output logic          div_ready_o,
  input  logic [AW-1:0] div_waddr_i,
  input  logic [DW-1:0] div_wdata_i,
  input  logic          jtag_valid_i,
  output logic          jtag_ready_o,
  input  logic [AW-1:0] jtag_addr_i,
  input  logic [DW-1:0] jtag_data_i,
  output logic          rf_we_o,
  output logic [AW-1:0] rf_waddr_o,
  output logic [DW-1:0] rf_wdata_o,
  output logic          pend_valid_o,
  output logic [AW-1:0] pend_addr_o,
  output logic          ex_stall_o
);

  logic          buf_v_q;
  logic [AW-1:0] buf_addr_q;
  logic [DW-1:0] buf_data_q;

  logic force_q;    // this cycle is the forced jtag slot
  logic stall;      // starvation limit reached: warn ex, hold the buffer
  logic force_gnt;
  logic ex_gnt;
  logic drain;
  logic jtag_gnt;
  logic div_acc;

`ifdef REGS_ARB_STARVE_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] starve_cnt_q;

  // force_q masks the limit so the stall lasts exactly one cycle even though
  // the saturated count is only cleared by the grant that follows it.
  assign stall = jtag_valid_i & (starve_cnt_q == CW'(STARVE_MAX)) & ~force_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_cnt_q <= '0;
      force_q      <= 1'b0;
    end else begin
      if (!jtag_valid_i || jtag_gnt) begin
        starve_cnt_q <= '0;
      end else if (starve_cnt_q != CW'(STARVE_MAX)) begin
        starve_cnt_q <= starve_cnt_q + CW'(1);
      end
      force_q <= stall & ~jtag_gnt;
    end
  end
`else
  // Strict priority; the parameter stays referenced so the default build
  // carries no unused-parameter noise.
  assign stall   = 1'b0 & (STARVE_MAX > 0);
  assign force_q = 1'b0;
`endif

  // Outputs are gated by rst_ni so nothing handshakes or writes while reset
  // is asserted, even before the first clock edge.
  assign force_gnt    = force_q & jtag_valid_i;
  assign ex_gnt       = rst_ni & ex_we_i & ~force_gnt;
  assign drain        = rst_ni & buf_v_q & ~ex_we_i & ~stall & ~force_gnt;
  assign jtag_gnt     = rst_ni & jtag_valid_i & (force_q | (~ex_we_i & ~buf_v_q));
  assign div_ready_o  = rst_ni & (~buf_v_q | drain);
  assign div_acc      = div_valid_i & div_ready_o;
  assign jtag_ready_o = jtag_gnt;
  assign ex_stall_o   = rst_ni & stall;
  assign pend_valid_o = buf_v_q;
  assign pend_addr_o  = buf_addr_q;

  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    if (ex_gnt) begin
      rf_we_o    = |ex_waddr_i;
      rf_waddr_o = ex_waddr_i;
      rf_wdata_o = ex_wdata_i;
    end else if (drain) begin
      rf_we_o    = |buf_addr_q;
      rf_waddr_o = buf_addr_q;
      rf_wdata_o = buf_data_q;
    end else if (jtag_gnt) begin
      rf_we_o    = |jtag_addr_i;
      rf_waddr_o = jtag_addr_i;
      rf_wdata_o = jtag_data_i;
    end
  end

  // A result for x0 is accepted but never buffered, so it cannot stall id.
  // Load takes precedence over drain: refill and write share the same edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_v_q    <= 1'b0;
      buf_addr_q <= '0;
      buf_data_q <= '0;
    end else if (div_acc && (|div_waddr_i)) begin
      buf_v_q    <= 1'b1;
      buf_addr_q <= div_waddr_i;
      buf_data_q <= div_wdata_i;
    end else if (drain) begin
      buf_v_q <= 1'b0;
    end
  end

endmodule
